pipeline_hazard_tracker: RTL
============================

Name: pipeline_hazard_tracker

Overview:
Parametrised hazard and forwarding controller for the in-order RV pipeline. It replaces the fixed 5-stage hazard logic with a shift-register scoreboard of in-flight writers covering DEPTH post-decode stages. Each writer carries its own result-availability stage, so variable-latency units (ALU, load, future multiply) are handled uniformly. It also adds a backend freeze for multi-cycle memory wait. It sits beside the datapath and drives its stall, flush and forward-select inputs.

Parameters:
GPR_BITS, 5, width of a register index
DEPTH, 3, tracked stages after decode: index 0 = execute, 1 = memory, ..., DEPTH-1 = writeback; must be at least 2
FWD_BITS, $clog2(DEPTH), width of forward selects and availability stage

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
decode_valid  in  1  decode holds a real instruction
rs1_decode, rs2_decode  in  GPR_BITS  source registers in decode
rd_decode  in  GPR_BITS  destination in decode
we_gpr_decode  in  1  decode instruction writes the GPR file
avail_decode  in  FWD_BITS  first stage index whose register holds the result (ALU = 1, load = 2); 0 is treated as 1
branch_taken  in  1  redirect resolved in execute
mem_wait  in  1  data memory not ready; freeze backend
stall_fetch, stall_decode  out  1  hold PC and decode register
flush_decode, flush_execute  out  1  insert bubble
stall_backend  out  1  hold execute, memory and writeback registers
forward_rs1, forward_rs2  out  FWD_BITS  execute operand source: 0 = register value, j = stage-j result

Behaviour:
- One clock, clk; reset is synchronous and active-high, named reset.
- State: DEPTH entries {valid, rd, we, avail, rs1, rs2}. Entry 0 describes the instruction currently in execute.
- Reset: all valid bits cleared at the edge. While reset is high, all outputs are 0 except flush_decode = flush_execute = 1.
- Writer(j, r): entry j is valid, we = 1, rd = r, and r != 0. x0 never creates a hazard or forward.
- load_use = decode_valid and, for some j in 0..DEPTH-2 and some rs of decode, Writer(j, rs) holds with avail > j+1. Stage DEPTH-1 is covered by register-file write-through.
- Forwarding is combinational from state and applies to the entry-0 operands. For each rs, pick the smallest j in 1..DEPTH-1 with Writer(j, rs).
  - If j >= avail, output j.
  - Otherwise, or if no match, output 0.
  - The youngest writer always wins over older ones.
- Priority, evaluated each cycle:
  1. mem_wait: stall_fetch = stall_decode = stall_backend = 1, flushes 0, entries hold. A pending branch_taken is deferred because the branch stays in execute.
  2. branch_taken: flush_decode = flush_execute = 1, stalls 0. Entries shift; entry 0 becomes invalid.
  3. load_use: stall_fetch = stall_decode = 1, flush_execute = 1. Entries shift; entry 0 becomes invalid (bubble).
  4. Otherwise: entries shift; entry 0 is loaded from the decode fields with valid = decode_valid.
- Shift means entry j+1 takes entry j, and entry DEPTH-1 retires. Forward outputs are stable throughout a freeze.
- Latency: the stall is 1 cycle per bubble needed. For a consumer directly behind a writer with availability a, total bubbles = a-1.

Decomposition:
- Shared package: the tracker entry struct, the FWD_NONE = 0 constant, and the ALU and load availability constants (AVAIL_ALU = 1, AVAIL_LOAD = 2).
- One natural sub-module: hazard_match. It is a combinational comparator of one rs against all entries and returns the youngest-match index plus a ready flag. It is instantiated 4 times (decode rs1/rs2 for stall, execute rs1/rs2 for forward).

Test Plan:
- DEPTH = 3: issue rd = 5 with avail 1, then the next instruction reads rs1 = 5 → no stall; one cycle later forward_rs1 = 1.
- Load rd = 5 with avail 2, immediately followed by a reader of rs2 = 5 → one cycle of stall_decode = stall_fetch = flush_execute = 1; then stall 0; at the reader's execute cycle forward_rs2 = 2.
- x5 written by an older and a younger ALU instruction (entries at stage 2 and stage 1) → forward_rs1 = 1; a writer with rd = 0 followed by a reader of x0 → no stall, forward 0.
- branch_taken in the same cycle as a load_use condition → flush_decode = flush_execute = 1, stall_fetch = 0; the next cycle entry 0 is invalid.
- mem_wait held 3 cycles during a load-use pair, with branch_taken asserted in cycle 2 → all stalls = 1, flushes 0, forwards unchanged. After release the sequence resumes exactly as without the wait, and the flush occurs in the first unfrozen cycle.
- reset asserted for one cycle with 3 valid entries → after the edge: all outputs 0, and an immediate reader of a previously pending rd gets no stall and forward 0.

Source files
------------

// File: rtl/pipeline_hazard_tracker_pkg.sv
// Shared types and constants for the pipeline hazard tracker.
// Entry fields are stored at fixed maximum widths. Narrower register indices
// and stage numbers are zero-extended into them, so the storage format does
// not change when the top-level parameters do.
package pipeline_hazard_tracker_pkg;

  localparam int GPR_BITS_MAX = 8;
  localparam int FWD_BITS_MAX = 4;

  typedef logic [GPR_BITS_MAX-1:0] gpr_t;
  typedef logic [FWD_BITS_MAX-1:0] stage_t;

  // Writer view of an in-flight instruction. Every tracked stage needs this part.
  typedef struct packed {
    logic   valid;
    logic   we;
    gpr_t   rd;
    stage_t avail;
  } writer_t;

  // Full tracker entry. Only the execute stage still needs its source operands.
  typedef struct packed {
    writer_t w;
    gpr_t    rs1;
    gpr_t    rs2;
  } entry_t;

  localparam stage_t FWD_NONE   = stage_t'(0);
  localparam stage_t AVAIL_ALU  = stage_t'(1);
  localparam stage_t AVAIL_LOAD = stage_t'(2);

  // An availability of 0 would mean "ready in execute", which no unit provides.
  function automatic stage_t norm_avail(input stage_t a);
    return (a == FWD_NONE) ? AVAIL_ALU : a;
  endfunction

endpackage

// File: rtl/pipeline_hazard_tracker_hazard_match.sv
// Combinational comparator of one source register against the tracked writers.
// Only stages LO..HI are considered. The youngest (smallest index) match wins.
// Ports:
//   rs_i      source register index (zero-extended)
//   writers_i writer view of every tracked stage, index 0 = execute
//   hit_o     some writer in LO..HI targets rs_i (x0 never matches)
//   idx_o     stage index of the youngest matching writer
//   ready_o   that writer's result is available at a consumer located
//             OFFSET stages younger than the writer's stage
module pipeline_hazard_tracker_hazard_match
  import pipeline_hazard_tracker_pkg::*;
#(
  parameter int DEPTH    = 3,
  parameter int FWD_BITS = 2,
  parameter int LO       = 0,
  parameter int HI       = 1,
  parameter int OFFSET   = 0
) (
  input  gpr_t                rs_i,
  input  writer_t             writers_i [DEPTH],
  output logic                hit_o,
  output logic [FWD_BITS-1:0] idx_o,
  output logic                ready_o
);

  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    ready_o = 1'b0;
    // Scan oldest to youngest so the youngest match overwrites the older ones.
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (j >= LO && j <= HI && writers_i[j].valid && writers_i[j].we &&
          writers_i[j].rd == rs_i && rs_i != '0) begin
        hit_o   = 1'b1;
        idx_o   = FWD_BITS'(j);
        ready_o = stage_t'(j + OFFSET) >= writers_i[j].avail;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_tracker.sv
// Hazard and forwarding controller for the in-order pipeline.
// It keeps a shift-register scoreboard of DEPTH post-decode stages. Entry 0 is
// execute and entry DEPTH-1 is writeback. Each writer carries the first stage at
// which its result exists. DEPTH must be at least 2.
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   decode_valid, rs1/rs2/rd_decode, we_gpr_decode, avail_decode
//                                instruction currently in decode
//   branch_taken                 redirect resolved in execute
//   mem_wait                     data memory busy, freeze the backend
//   stall_fetch/decode/backend   hold controls
//   flush_decode/execute         bubble insertion
//   forward_rs1/rs2              execute operand source, 0 = register file
module pipeline_hazard_tracker
  import pipeline_hazard_tracker_pkg::*;
#(
  parameter int GPR_BITS = 5,
  parameter int DEPTH    = 3,
  parameter int FWD_BITS = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                decode_valid,
  input  logic [GPR_BITS-1:0] rs1_decode,
  input  logic [GPR_BITS-1:0] rs2_decode,
  input  logic [GPR_BITS-1:0] rd_decode,
  input  logic                we_gpr_decode,
  input  logic [FWD_BITS-1:0] avail_decode,
  input  logic                branch_taken,
  input  logic                mem_wait,
  output logic                stall_fetch,
  output logic                stall_decode,
  output logic                flush_decode,
  output logic                flush_execute,
  output logic                stall_backend,
  output logic [FWD_BITS-1:0] forward_rs1,
  output logic [FWD_BITS-1:0] forward_rs2
);

  entry_t  ex_q, ex_d;
  writer_t wb_q [DEPTH-1];
  writer_t wb_d [DEPTH-1];
  writer_t writers [DEPTH];
  entry_t  dec_entry;

  logic                dec_hit1, dec_rdy1, dec_hit2, dec_rdy2;
  logic                ex_hit1, ex_rdy1, ex_hit2, ex_rdy2;
  logic [FWD_BITS-1:0] ex_idx1, ex_idx2;
  logic [FWD_BITS-1:0] unused_dec_idx1, unused_dec_idx2;
  logic                load_use;

  always_comb begin
    writers[0] = ex_q.w;
    for (int j = 1; j < DEPTH; j++) writers[j] = wb_q[j-1];
  end

  always_comb begin
    dec_entry.w.valid = decode_valid;
    dec_entry.w.we    = we_gpr_decode;
    dec_entry.w.rd    = gpr_t'(rd_decode);
    dec_entry.w.avail = norm_avail(stage_t'(avail_decode));
    dec_entry.rs1     = gpr_t'(rs1_decode);
    dec_entry.rs2     = gpr_t'(rs2_decode);
  end

  // Decode side: a writer at stage j reaches decode's consumer one stage later.
  // The writeback stage is excluded because the register file writes through.
  pipeline_hazard_tracker_hazard_match #(
    .DEPTH(DEPTH), .FWD_BITS(FWD_BITS), .LO(0), .HI(DEPTH-2), .OFFSET(1)
  ) u_dec_rs1 (
    .rs_i(gpr_t'(rs1_decode)), .writers_i(writers),
    .hit_o(dec_hit1), .idx_o(unused_dec_idx1), .ready_o(dec_rdy1)
  );

  pipeline_hazard_tracker_hazard_match #(
    .DEPTH(DEPTH), .FWD_BITS(FWD_BITS), .LO(0), .HI(DEPTH-2), .OFFSET(1)
  ) u_dec_rs2 (
    .rs_i(gpr_t'(rs2_decode)), .writers_i(writers),
    .hit_o(dec_hit2), .idx_o(unused_dec_idx2), .ready_o(dec_rdy2)
  );

  // Execute side: forward from the youngest older writer whose result exists.
  pipeline_hazard_tracker_hazard_match #(
    .DEPTH(DEPTH), .FWD_BITS(FWD_BITS), .LO(1), .HI(DEPTH-1), .OFFSET(0)
  ) u_ex_rs1 (
    .rs_i(ex_q.rs1), .writers_i(writers),
    .hit_o(ex_hit1), .idx_o(ex_idx1), .ready_o(ex_rdy1)
  );

  pipeline_hazard_tracker_hazard_match #(
    .DEPTH(DEPTH), .FWD_BITS(FWD_BITS), .LO(1), .HI(DEPTH-1), .OFFSET(0)
  ) u_ex_rs2 (
    .rs_i(ex_q.rs2), .writers_i(writers),
    .hit_o(ex_hit2), .idx_o(ex_idx2), .ready_o(ex_rdy2)
  );

  assign load_use = decode_valid & ((dec_hit1 & ~dec_rdy1) | (dec_hit2 & ~dec_rdy2));

  always_comb begin
    ex_d = ex_q;
    wb_d = wb_q;
    if (reset) begin
      ex_d = '0;
      for (int j = 0; j < DEPTH - 1; j++) wb_d[j] = '0;
    end else if (!mem_wait) begin
      wb_d[0] = ex_q.w;
      for (int j = 1; j < DEPTH - 1; j++) wb_d[j] = wb_q[j-1];
      ex_d = (branch_taken || load_use) ? '0 : dec_entry;
    end
  end

  always_ff @(posedge clk) begin
    ex_q <= ex_d;
    wb_q <= wb_d;
  end

  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_backend = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    forward_rs1   = '0;
    forward_rs2   = '0;
    if (reset) begin
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else begin
      forward_rs1 = (ex_hit1 && ex_rdy1) ? ex_idx1 : '0;
      forward_rs2 = (ex_hit2 && ex_rdy2) ? ex_idx2 : '0;
      // A branch seen during a freeze stays in execute and is reported again later.
      if (mem_wait) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_backend = 1'b1;
      end else if (branch_taken) begin
        flush_decode  = 1'b1;
        flush_execute = 1'b1;
      end else if (load_use) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        flush_execute = 1'b1;
      end
    end
  end

endmodule
